alu_arbiter: RTL and testbench

//  Shares one combinational ALU (driven through alu_if.tb) between NREQ requesters, e.g. execute

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu.sv | 42 ++++
 rtl/alu_arbiter_rr.sv | 33 +++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: ALU word/opcode types and the arbiter FSM state.
package alu_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_HOLD} alu_arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between requesters and the arbiter, plus the shared-ALU interface.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  import alu_arbiter_pkg::*;
  localparam int IDW = id_width(NREQ);

  logic   [NREQ-1:0] req_valid;
  logic   [NREQ-1:0] req_ready;
  aluop_t [NREQ-1:0] req_opcode;
  word_t  [NREQ-1:0] req_portA;
  word_t  [NREQ-1:0] req_portB;

  logic              resp_valid;
  logic              resp_ready;
  logic   [IDW-1:0]  resp_id;
  word_t             resp_outPort;
  logic              resp_neg;
  logic              resp_ovf;
  logic              resp_zero;

  modport master (
    output req_valid, req_opcode, req_portA, req_portB, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_outPort, resp_neg, resp_ovf, resp_zero
  );

  modport slave (
    input  req_valid, req_opcode, req_portA, req_portB, resp_ready,
    output req_ready, resp_valid, resp_id, resp_outPort, resp_neg, resp_ovf, resp_zero
  );
endinterface

interface alu_if;
  import alu_arbiter_pkg::*;

  aluop_t opcode;
  word_t  portA;
  word_t  portB;
  word_t  outPort;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport tb  (output opcode, portA, portB, input  outPort, negative, overflow, zero);
  modport alu (input  opcode, portA, portB, output outPort, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter's requesters.
module alu
  import alu_arbiter_pkg::*;
(
  alu_if.alu aif
);

  word_t res;
  logic  ovf;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aif.opcode)
      ALU_SLL:  res = aif.portA << aif.portB[4:0];
      ALU_SRL:  res = aif.portA >> aif.portB[4:0];
      ALU_SRA:  res = word_t'($signed(aif.portA) >>> aif.portB[4:0]);
      ALU_ADD: begin
        res = aif.portA + aif.portB;
        ovf = (aif.portA[WORD_W-1] == aif.portB[WORD_W-1]) &&
              (res[WORD_W-1] != aif.portA[WORD_W-1]);
      end
      ALU_SUB: begin
        res = aif.portA - aif.portB;
        ovf = (aif.portA[WORD_W-1] != aif.portB[WORD_W-1]) &&
              (res[WORD_W-1] != aif.portA[WORD_W-1]);
      end
      ALU_AND:  res = aif.portA & aif.portB;
      ALU_OR:   res = aif.portA | aif.portB;
      ALU_XOR:  res = aif.portA ^ aif.portB;
      ALU_SLT:  res = {{(WORD_W-1){1'b0}}, $signed(aif.portA) < $signed(aif.portB)};
      ALU_SLTU: res = {{(WORD_W-1){1'b0}}, aif.portA < aif.portB};
      default:  res = '0;
    endcase
  end

  assign aif.outPort  = res;
  assign aif.negative = res[WORD_W-1];
  assign aif.overflow = ovf;
  assign aif.zero     = (res == '0);

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_idx_o,
  output logic           any_o
);

  int   j;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        grant_o[j]  = 1'b1;
        grant_idx_o = IDW'(j);
        found       = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters; one op in flight, registered response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               CLK,
  input  logic               RST,
  alu_arbiter_if.slave       arb,
  alu_if.tb                  aluif,
  output logic [31:0]        op_count
);

  localparam int IDW = id_width(NREQ);

  alu_arb_state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d;

  aluop_t         lat_op_q, lat_op_d;
  word_t          lat_a_q, lat_a_d;
  word_t          lat_b_q, lat_b_d;
  logic [IDW-1:0] lat_id_q, lat_id_d;

  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  word_t          resp_out_q, resp_out_d;
  logic           resp_neg_q, resp_neg_d;
  logic           resp_ovf_q, resp_ovf_d;
  logic           resp_zero_q, resp_zero_d;
  logic [31:0]    op_count_q, op_count_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            can_grant;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
    .req_i       (arb.req_valid),
    .last_ptr_i  (last_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    lat_op_d      = lat_op_q;
    lat_a_d       = lat_a_q;
    lat_b_d       = lat_b_q;
    lat_id_d      = lat_id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_out_d    = resp_out_q;
    resp_neg_d    = resp_neg_q;
    resp_ovf_d    = resp_ovf_q;
    resp_zero_d   = resp_zero_q;
    op_count_d    = op_count_q;
    arb.req_ready = '0;
    can_grant     = 1'b0;

    case (state_q)
      ARB_IDLE: can_grant = 1'b1;
      ARB_EXEC: begin
        resp_valid_d = 1'b1;
        resp_id_d    = lat_id_q;
        resp_out_d   = aluif.outPort;
        resp_neg_d   = aluif.negative;
        resp_ovf_d   = aluif.overflow;
        resp_zero_d  = aluif.zero;
        state_d      = ARB_HOLD;
      end
      ARB_HOLD: begin
        if (arb.resp_ready) begin
          op_count_d   = op_count_q + 32'd1;
          resp_valid_d = 1'b0;
          state_d      = ARB_IDLE;
          can_grant    = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // A grant fires either from IDLE or back-to-back with a consumed response.
    if (can_grant && grant_any && !RST) begin
      arb.req_ready = grant;
      lat_op_d      = arb.req_opcode[grant_idx];
      lat_a_d       = arb.req_portA[grant_idx];
      lat_b_d       = arb.req_portB[grant_idx];
      lat_id_d      = grant_idx;
      last_d        = grant_idx;
      state_d       = ARB_EXEC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ARB_IDLE;
      last_q       <= IDW'(NREQ - 1);
      lat_op_q     <= ALU_SLL;
      lat_a_q      <= '0;
      lat_b_q      <= '0;
      lat_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_out_q   <= '0;
      resp_neg_q   <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      lat_op_q     <= lat_op_d;
      lat_a_q      <= lat_a_d;
      lat_b_q      <= lat_b_d;
      lat_id_q     <= lat_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      resp_neg_q   <= resp_neg_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_zero_q  <= resp_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  // The ALU only ever sees latched operands, so it stays quiet between operations.
  assign aluif.opcode = lat_op_q;
  assign aluif.portA  = lat_a_q;
  assign aluif.portB  = lat_b_q;

  assign arb.resp_valid   = resp_valid_q;
  assign arb.resp_id      = resp_id_q;
  assign arb.resp_outPort = resp_out_q;
  assign arb.resp_neg     = resp_neg_q;
  assign arb.resp_ovf     = resp_ovf_q;
  assign arb.resp_zero    = resp_zero_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a queue-based scoreboard and a negedge response monitor.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [31:0] id;
    logic [31:0] out;
    logic        neg;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] op_count;
  int          total;
  int          bad;
  exp_t        exp_q[$];

  alu_if             aif ();
  alu_arbiter_if #(.NREQ(2)) bif ();

  alu u_alu (.aif(aif));

  alu_arbiter #(.NREQ(2)) dut (
    .CLK      (clk),
    .RST      (rst),
    .arb      (bif),
    .aluif    (aif),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [31:0] out, input logic n, input logic o,
                      input logic z);
    exp_t e;
    e.id = id; e.out = out; e.neg = n; e.ovf = o; e.zero = z;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input aluop_t op, input logic [31:0] a,
                         input logic [31:0] b);
    bif.req_opcode[i] = op;
    bif.req_portA[i]  = a;
    bif.req_portB[i]  = b;
  endtask

  // Monitor: every consumed response is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bif.resp_valid && bif.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_id", 32'(bif.resp_id), e.id);
        chk("resp_outPort", bif.resp_outPort, e.out);
        chk("resp_neg", 32'(bif.resp_neg), 32'(e.neg));
        chk("resp_ovf", 32'(bif.resp_ovf), 32'(e.ovf));
        chk("resp_zero", 32'(bif.resp_zero), 32'(e.zero));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bif.req_valid  = 2'b01;
    bif.resp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, ALU_ADD, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_req_ready", 32'(bif.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    chk("rst_resp_out", bif.resp_outPort, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    rst = 1'b0;
    bif.req_valid = 2'b00;
    tick();

    // 1: single ADD from requester 0, latency and operand isolation after fire
    bif.resp_ready = 1'b1;
    set_req(0, ALU_ADD, 32'd5, 32'd3);
    bif.req_valid = 2'b01;
    #1;
    chk("t1_req_ready", 32'(bif.req_ready), 32'd1);
    push(0, 32'd8, 1'b0, 1'b0, 1'b0);
    tick();
    bif.req_valid = 2'b00;
    set_req(0, ALU_ADD, 32'd99, 32'd99);
    #1;
    chk("t1_valid_n1", 32'(bif.resp_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(bif.resp_valid), 32'd1);
    tick();
    chk("t1_op_count", op_count, 32'd1);
    chk("t1_valid_after", 32'(bif.resp_valid), 32'd0);

    // 2: signed overflow into negative
    set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    bif.req_valid = 2'b10;
    #1;
    chk("t2_req_ready", 32'(bif.req_ready), 32'd2);
    push(1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    bif.req_valid = 2'b00;
    tick();
    tick();
    chk("t2_op_count", op_count, 32'd2);

    // 3: both requesters continuously valid, back-to-back alternating grants
    set_req(0, ALU_SUB, 32'd4, 32'd4);
    set_req(1, ALU_SUB, 32'd4, 32'd4);
    bif.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) push(k % 2, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_grant", 32'(bif.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      if (k == 3) bif.req_valid = 2'b00;
      #1;
      chk("t3_exec_valid", 32'(bif.resp_valid), 32'd0);
      tick();
      chk("t3_hold_valid", 32'(bif.resp_valid), 32'd1);
    end
    tick();
    chk("t3_op_count", op_count, 32'd6);

    // 4: back-pressure holds the response and blocks new grants
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    bif.req_valid = 2'b01;
    #1;
    chk("t4_first_grant", 32'(bif.req_ready), 32'd1);
    push(0, 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    bif.resp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd10, 32'd20);
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    bif.req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_valid", 32'(bif.resp_valid), 32'd1);
      chk("t4_stall_out", bif.resp_outPort, 32'd3);
      chk("t4_stall_ready", 32'(bif.req_ready), 32'd0);
      tick();
    end
    bif.resp_ready = 1'b1;
    #1;
    chk("t4_release_grant", 32'(bif.req_ready), 32'd2);
    push(1, 32'd2, 1'b0, 1'b0, 1'b0);
    tick();
    bif.req_valid = 2'b00;
    tick();
    tick();
    chk("t4_op_count", op_count, 32'd8);

    // 5: reset during EXEC discards the op and restores requester-0 priority
    set_req(0, ALU_ADD, 32'd7, 32'd7);
    bif.req_valid = 2'b01;
    tick();
    bif.req_valid = 2'b00;
    rst = 1'b1;
    tick();
    chk("t5_resp_valid", 32'(bif.resp_valid), 32'd0);
    chk("t5_op_count", op_count, 32'd0);
    rst = 1'b0;
    set_req(0, ALU_SUB, 32'd4, 32'd4);
    set_req(1, ALU_SUB, 32'd9, 32'd4);
    bif.req_valid = 2'b11;
    #1;
    chk("t5_priority", 32'(bif.req_ready), 32'd1);
    push(0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    bif.req_valid = 2'b00;
    tick();
    tick();
    chk("t5_op_count_after", op_count, 32'd1);

    // 6: op_count wraps from all-ones to zero
    force dut.op_count_q = 32'hFFFF_FFFF;
    set_req(1, ALU_AND, 32'h0000_00F0, 32'h0000_003C);
    bif.req_valid = 2'b10;
    push(1, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    tick();
    bif.req_valid = 2'b00;
    tick();
    release dut.op_count_q;
    tick();
    chk("t6_wrap", op_count, 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
